// File: rtl/sync_fifo_pkg.sv
// Shared constants and types for the synchronous FIFO controller.
package sync_fifo_pkg;

    localparam int DWIDTH_DEF = 8;
    localparam int AWIDTH_DEF = 4;

    // Status flag bundle produced from registered pointer state
    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_status_t;

endpackage : sync_fifo_pkg

// File: rtl/sync_fifo_mem.sv
// FIFO storage: one synchronous write port, one registered read port, no reset.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int AWIDTH = AWIDTH_DEF
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [AWIDTH-1:0] i_wr_addr,
    input  logic [DWIDTH-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [AWIDTH-1:0] i_rd_addr,
    output logic [DWIDTH-1:0] o_rd_data
);

    logic [DWIDTH-1:0] r_mem [2**AWIDTH];
    logic [DWIDTH-1:0] r_rd_data;

    // Store the write word at the addressed location
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Capture the read word; holds its value when no read is requested
    always_ff @(posedge clk) begin
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule : sync_fifo_mem

// File: rtl/sync_fifo_ctrl.sv
// Synchronous FIFO controller: pointers, occupancy, status flags and
// optional sticky overflow/underflow flags (enabled by SYNC_FIFO_ERR_EN).
module sync_fifo_ctrl
    import sync_fifo_pkg::*;
#(
    parameter int DWIDTH    = DWIDTH_DEF,
    parameter int AWIDTH    = AWIDTH_DEF,
    parameter int AFULL_TH  = (2**AWIDTH) - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic              clk,
    input  logic              rst,
`ifdef SYNC_FIFO_ERR_EN
    input  logic              err_clr,
    output logic              overflow,
    output logic              underflow,
`endif
    input  logic              wr_en,
    input  logic [DWIDTH-1:0] din,
    input  logic              rd_en,
    output logic [DWIDTH-1:0] dout,
    output logic              dout_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [AWIDTH:0]   count
);

    localparam logic [AWIDTH:0] DEPTH_V     = {1'b1, {AWIDTH{1'b0}}};
    localparam logic [AWIDTH:0] AFULL_TH_V  = AFULL_TH[AWIDTH:0];
    localparam logic [AWIDTH:0] AEMPTY_TH_V = AEMPTY_TH[AWIDTH:0];

    logic [AWIDTH:0]   r_wptr;
    logic [AWIDTH:0]   r_rptr;
    logic              r_dout_valid;
    logic              r_rd_seen;     // a read has completed since reset
    logic [AWIDTH:0]   w_count;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [DWIDTH-1:0] w_rd_data;
    fifo_status_t      w_status;

    assign w_count  = r_wptr - r_rptr;
    assign w_wr_acc = wr_en && !w_status.full;
    assign w_rd_acc = rd_en && !w_status.empty;

    // Derive status flags from the registered occupancy
    always_comb begin
        w_status              = '0;
        w_status.empty        = (w_count == {(AWIDTH+1){1'b0}});
        w_status.full         = (w_count == DEPTH_V);
        w_status.almost_full  = (w_count >= AFULL_TH_V);
        w_status.almost_empty = (w_count <= AEMPTY_TH_V);
    end

    // Advance write/read pointers on accepted transfers; wrap bit rides in the MSB
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= {(AWIDTH+1){1'b0}};
            r_rptr <= {(AWIDTH+1){1'b0}};
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + {{AWIDTH{1'b0}}, 1'b1};
            end
            if (w_rd_acc) begin
                r_rptr <= r_rptr + {{AWIDTH{1'b0}}, 1'b1};
            end
        end
    end

    // Flag fresh read data; r_rd_seen masks the unreset read register to zero after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout_valid <= 1'b0;
            r_rd_seen    <= 1'b0;
        end else begin
            r_dout_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_seen <= 1'b1;
            end
        end
    end

    sync_fifo_mem #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wptr[AWIDTH-1:0]),
        .i_wr_data (din),
        .i_rd_en   (w_rd_acc),
        .i_rd_addr (r_rptr[AWIDTH-1:0]),
        .o_rd_data (w_rd_data)
    );

    assign dout         = r_rd_seen ? w_rd_data : {DWIDTH{1'b0}};
    assign dout_valid   = r_dout_valid;
    assign full         = w_status.full;
    assign empty        = w_status.empty;
    assign almost_full  = w_status.almost_full;
    assign almost_empty = w_status.almost_empty;
    assign count        = w_count;

`ifdef SYNC_FIFO_ERR_EN
    logic r_overflow;
    logic r_underflow;

    // Sticky violation flags; a new violation wins over a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en && w_status.full) begin
                r_overflow <= 1'b1;
            end else if (err_clr) begin
                r_overflow <= 1'b0;
            end
            if (rd_en && w_status.empty) begin
                r_underflow <= 1'b1;
            end else if (err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

endmodule : sync_fifo_ctrl

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench for sync_fifo_ctrl against a queue-based FIFO model.
module tb_sync_fifo_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [DW-1:0] din;
    logic          rd_en;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          full, empty, almost_full, almost_empty;
    logic [AW:0]   count;
    logic          err_clr;
`ifdef SYNC_FIFO_ERR_EN
    logic          overflow, underflow;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    logic [DW-1:0] model_q[$];
    logic [DW-1:0] exp_dout;
    logic          exp_valid;
    logic          exp_ovf;
    logic          exp_udf;

    sync_fifo_ctrl #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef SYNC_FIFO_ERR_EN
        .err_clr      (err_clr),
        .overflow     (overflow),
        .underflow    (underflow),
`endif
        .wr_en        (wr_en),
        .din          (din),
        .rd_en        (rd_en),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model's view of the FIFO
    task automatic check_all(input string ctx);
        int sz;
        sz = model_q.size();
        chk({ctx, ".count"},        32'(count),        32'(sz));
        chk({ctx, ".full"},         32'(full),         32'(sz == DEPTH));
        chk({ctx, ".empty"},        32'(empty),        32'(sz == 0));
        chk({ctx, ".almost_full"},  32'(almost_full),  32'(sz >= DEPTH - 2));
        chk({ctx, ".almost_empty"}, 32'(almost_empty), 32'(sz <= 2));
        chk({ctx, ".dout"},         32'(dout),         32'(exp_dout));
        chk({ctx, ".dout_valid"},   32'(dout_valid),   32'(exp_valid));
`ifdef SYNC_FIFO_ERR_EN
        chk({ctx, ".overflow"},     32'(overflow),     32'(exp_ovf));
        chk({ctx, ".underflow"},    32'(underflow),    32'(exp_udf));
`endif
    endtask

    // One clock cycle of stimulus followed by model update and full check
    task automatic step(input string ctx, input logic we, input logic re,
                        input logic [DW-1:0] d, input logic clr);
        int sz;
        bit wa, ra;
        @(negedge clk);
        wr_en = we; rd_en = re; din = d; err_clr = clr;
        sz = model_q.size();
        wa = we && (sz < DEPTH);
        ra = re && (sz > 0);
        @(posedge clk);
        #1;
        exp_valid = ra;
        if (ra) exp_dout = model_q.pop_front();
        if (wa) model_q.push_back(d);
        if (we && sz == DEPTH) exp_ovf = 1'b1;
        else if (clr)          exp_ovf = 1'b0;
        if (re && sz == 0)     exp_udf = 1'b1;
        else if (clr)          exp_udf = 1'b0;
        check_all(ctx);
    endtask

    task automatic model_reset();
        model_q.delete();
        exp_dout  = '0;
        exp_valid = 1'b0;
        exp_ovf   = 1'b0;
        exp_udf   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0; err_clr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Fill with 0x00..0x0F, then a dropped 17th write
        for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 1'b0, 8'(i), 1'b0);
        step("fill_drop", 1'b1, 1'b0, 8'hEE, 1'b0);
        chk("fill_drop.count16", 32'(count), 32'd16);

        // Drain in order, then a read on empty
        for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, 1'b1, 8'h00, 1'b0);
        step("drain_empty", 1'b0, 1'b1, 8'h00, 1'b0);
        chk("drain_empty.dout0F", 32'(dout), 32'h0F);

        // Steady state at count 8 with simultaneous traffic across pointer wraps
        for (int i = 0; i < 8; i++) step("half", 1'b1, 1'b0, 8'($urandom), 1'b0);
        for (int i = 0; i < 20; i++) step("stream", 1'b1, 1'b1, 8'($urandom), 1'b0);
        chk("stream.count8", 32'(count), 32'd8);

        // Full with both requests: read only
        for (int i = 0; i < 8; i++) step("refill", 1'b1, 1'b0, 8'($urandom), 1'b0);
        step("full_both", 1'b1, 1'b1, 8'h77, 1'b0);
        chk("full_both.count15", 32'(count), 32'd15);

        // Empty with both requests: write only, no bypass
        for (int i = 0; i < 15; i++) step("empty_out", 1'b0, 1'b1, 8'h00, 1'b0);
        step("empty_both", 1'b1, 1'b1, 8'h3C, 1'b0);
        chk("empty_both.count1", 32'(count), 32'd1);
        step("empty_both_rd", 1'b0, 1'b1, 8'h00, 1'b0);

        // Asynchronous reset mid-cycle at count 9
        for (int i = 0; i < 9; i++) step("pre_rst", 1'b1, 1'b0, 8'($urandom), 1'b0);
        chk("pre_rst.count9", 32'(count), 32'd9);
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        #1 rst = 1'b0;
        step("post_rst_wr", 1'b1, 1'b0, 8'hA5, 1'b0);
        step("post_rst_rd", 1'b0, 1'b1, 8'h00, 1'b0);
        chk("post_rst_rd.A5", 32'(dout), 32'hA5);

`ifdef SYNC_FIFO_ERR_EN
        // Sticky error flags and set-over-clear priority
        step("err_clr0", 1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < DEPTH; i++) step("err_fill", 1'b1, 1'b0, 8'(i), 1'b0);
        step("ovf_set", 1'b1, 1'b0, 8'h11, 1'b0);
        step("ovf_hold", 1'b0, 1'b0, 8'h00, 1'b0);
        step("ovf_setclr", 1'b1, 1'b0, 8'h22, 1'b1);
        chk("ovf_setclr.ovf1", 32'(overflow), 32'd1);
        step("ovf_clr", 1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < DEPTH; i++) step("err_drain", 1'b0, 1'b1, 8'h00, 1'b0);
        step("udf_set", 1'b0, 1'b1, 8'h00, 1'b0);
        step("udf_setclr", 1'b0, 1'b1, 8'h00, 1'b1);
        chk("udf_setclr.udf1", 32'(underflow), 32'd1);
        step("udf_clr", 1'b0, 1'b0, 8'h00, 1'b1);
`endif

        // Randomized traffic with varying bias toward write or read
        for (int i = 0; i < 400; i++) begin
            int bias;
            bias = (i / 100) % 2 == 0 ? 70 : 30;
            step("random", ($urandom_range(0, 99) < bias), ($urandom_range(0, 99) >= bias),
                 8'($urandom), ($urandom_range(0, 15) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_sync_fifo_ctrl
